// File: rtl/mmio_uart_tx_if.sv
// CPU-side register bus of the memory-mapped UART transmitter.
// The master drives a strobe-qualified access; the slave returns registered load data.
interface mmio_uart_tx_if;
  logic        sel;
  logic        addr;
  logic        write_en;
  logic        read_en;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, output addr, output write_en, output read_en,
                  output wdata, input rdata);
  modport slave  (input sel, input addr, input write_en, input read_en,
                  input wdata, output rdata);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA pushes into a FIFO drained as 8N1 frames on tx.
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_W        = 5
) (
  input  logic           clk_25mhz,
  input  logic           reset_n,
  mmio_uart_tx_if.slave  bus,
  output logic           tx,
  output logic           irq_empty
);

  localparam int PTR_W = CNT_W - 1;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  state_t           r_state;
  logic [15:0]      r_baud;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             r_irq_empty;
  logic [31:0]      r_rdata;
`ifdef UART_PARITY_EN
  logic             r_parity;
`endif

  logic        w_full;
  logic        w_empty;
  logic        w_busy;
  logic        w_wr_data;
  logic        w_push;
  logic        w_drop;
  logic        w_pop;
  logic        w_rd;
  logic        w_rd_status;
  logic        w_bit_end;
  logic [31:0] w_status;
  logic        w_unused;

  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_busy      = (r_state != S_IDLE);
  assign w_wr_data   = bus.sel & bus.write_en & ~bus.addr;
  // Fullness is judged before any same-cycle pop, so a write to a full FIFO always drops.
  assign w_push      = w_wr_data & ~w_full;
  assign w_drop      = w_wr_data & w_full;
  assign w_pop       = (r_state == S_IDLE) & ~w_empty;
  assign w_rd        = bus.sel & bus.read_en;
  assign w_rd_status = w_rd & bus.addr;
  assign w_bit_end   = (r_baud == 16'(CLKS_PER_BIT - 1));
  assign w_unused    = ^bus.wdata[31:8];

  always_comb begin
    w_status              = '0;
    w_status[CNT_W-1:0]   = r_count;
    w_status[8]           = w_empty;
    w_status[9]           = w_full;
    w_status[10]          = w_busy;
    w_status[11]          = r_overflow;
  end

  always_ff @(posedge clk_25mhz) begin
    if (w_push) r_mem[r_wptr] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk_25mhz) begin
    if (!reset_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A dropped write in the same cycle as a STATUS read keeps the flag set.
      if (w_drop)           r_overflow <= 1'b1;
      else if (w_rd_status) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (!reset_n) begin
      r_rdata     <= '0;
      r_irq_empty <= 1'b1;
    end else begin
      if (w_rd) r_rdata <= bus.addr ? w_status : 32'h0;
      r_irq_empty <= w_empty & ~w_busy;
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_baud <= '0;
          if (w_pop) begin
            r_shift <= r_mem[r_rptr];
`ifdef UART_PARITY_EN
            r_parity <= ^r_mem[r_rptr];
`endif
            r_state <= S_START;
            r_tx    <= 1'b0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_state   <= S_DATA;
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              r_state <= S_PARITY;
              r_tx    <= r_parity;
`else
              r_state <= S_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
`endif
        S_STOP: begin
          r_tx <= 1'b1;
          if (w_bit_end) begin
            r_baud  <= '0;
            r_state <= S_IDLE;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_baud  <= '0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign tx        = r_tx;
  assign irq_empty = r_irq_empty;
  assign bus.rdata = r_rdata;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: a 16-deep and a 4-deep instance share one stimulus bus.
// Expected serial frames are built from the byte value, start/stop levels and (optionally) even parity.
module tb_mmio_uart_tx;

  localparam int CPB = 4;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic tx16, tx4, irq16, irq4;
  logic [31:0] r;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mmio_uart_tx_if bus16 ();
  mmio_uart_tx_if bus4 ();

  assign bus4.sel      = bus16.sel;
  assign bus4.addr     = bus16.addr;
  assign bus4.write_en = bus16.write_en;
  assign bus4.read_en  = bus16.read_en;
  assign bus4.wdata    = bus16.wdata;

  mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16), .CNT_W(5)) u_dut16 (
    .clk_25mhz (clk),
    .reset_n   (reset_n),
    .bus       (bus16.slave),
    .tx        (tx16),
    .irq_empty (irq16)
  );

  mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .CNT_W(3)) u_dut4 (
    .clk_25mhz (clk),
    .reset_n   (reset_n),
    .bus       (bus4.slave),
    .tx        (tx4),
    .irq_empty (irq4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // All bus tasks start and end on a falling edge; the access lands on the rising edge in between.
  task automatic bus_write(input logic a, input logic [31:0] d);
    bus16.sel      = 1'b1;
    bus16.addr     = a;
    bus16.write_en = 1'b1;
    bus16.wdata    = d;
    @(negedge clk);
    bus16.sel      = 1'b0;
    bus16.write_en = 1'b0;
  endtask

  task automatic bus_read(input logic a, output logic [31:0] d);
    bus16.sel     = 1'b1;
    bus16.addr    = a;
    bus16.read_en = 1'b1;
    @(negedge clk);
    bus16.sel     = 1'b0;
    bus16.read_en = 1'b0;
    d = bus16.rdata;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Called on the falling edge right after the pop edge; checks tx on every falling edge of the frame.
  task automatic check_frame(input logic [7:0] d);
    logic [NB-1:0] bits;
    bits[0] = 1'b0;
    for (int j = 0; j < 8; j++) bits[j+1] = d[j];
`ifdef UART_PARITY_EN
    bits[9]  = ^d;
    bits[10] = 1'b1;
`else
    bits[9]  = 1'b1;
`endif
    for (int i = 0; i < NB*CPB; i++) begin
      chk("tx_bit", 32'(tx16), 32'(bits[i/CPB]));
      @(negedge clk);
    end
  endtask

  initial begin
    bus16.sel      = 1'b0;
    bus16.addr     = 1'b0;
    bus16.write_en = 1'b0;
    bus16.read_en  = 1'b0;
    bus16.wdata    = '0;
    reset_n        = 1'b0;

    // Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx16), 32'h1);
    chk("rst_irq", 32'(irq16), 32'h1);
    chk("rst_rdata", bus16.rdata, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_tx", 32'(tx16), 32'h1);
    bus_read(1'b1, r);
    chk("status_reset", r, 32'h100);
    bus_read(1'b0, r);
    chk("txdata_read_zero", r, 32'h0);
    bus_write(1'b1, 32'h55);
    @(negedge clk);
    chk("status_write_tx", 32'(tx16), 32'h1);
    bus_read(1'b1, r);
    chk("status_write_ignored", r, 32'h100);

    // Single byte: tx drops one cycle after the write, busy clears 41 cycles after it
    bus_write(1'b0, 32'h0000_00A5);
    @(negedge clk);
    check_frame(8'hA5);
    chk("irq_lag", 32'(irq16), 32'h0);
    @(negedge clk);
    chk("irq_after", 32'(irq16), 32'h1);
    bus_read(1'b1, r);
    chk("status_after_a5", r, 32'h100);

    // Back-to-back frames with exactly one idle cycle
    bus_write(1'b0, 32'h41);
    bus_write(1'b0, 32'h42);
    fork
      check_frame(8'h41);
      begin
        bus_read(1'b1, r);
        chk("b2b_status", r, 32'h401);
      end
    join
    chk("b2b_idle", 32'(tx16), 32'h1);
    @(negedge clk);
    check_frame(8'h42);

    // Overflow on the 4-deep instance
    do_reset();
    for (int i = 0; i < 6; i++) bus_write(1'b0, 32'h10 + 32'(i));
    bus_read(1'b1, r);
    chk("ovf_status4", bus4.rdata, 32'hE04);
    chk("ovf_status16", r, 32'h405);
    bus_read(1'b1, r);
    chk("ovf_clear4", bus4.rdata, 32'h604);

    // Wrap-around: 20 bytes through the 16-deep FIFO
    do_reset();
    fork
      begin
        for (int i = 0; i < 16; i++) bus_write(1'b0, 32'(i));
        repeat (200) @(negedge clk);
        for (int i = 16; i < 20; i++) bus_write(1'b0, 32'(i));
      end
      begin
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
          check_frame(8'(k));
          chk("wrap_idle", 32'(tx16), 32'h1);
          @(negedge clk);
        end
      end
    join
    bus_read(1'b1, r);
    chk("wrap_status", r, 32'h100);

    // Reset in the middle of data bit 3
    do_reset();
    bus_write(1'b0, 32'hA5);
    @(negedge clk);
    repeat (17) @(negedge clk);
    chk("mid_bit3", 32'(tx16), 32'h0);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx", 32'(tx16), 32'h1);
    reset_n = 1'b1;
    bus_read(1'b1, r);
    chk("mid_rst_status", r, 32'h100);
    bus_write(1'b0, 32'h3C);
    @(negedge clk);
    check_frame(8'h3C);

    // Parity-sensitive bytes
    @(negedge clk);
    bus_write(1'b0, 32'h07);
    @(negedge clk);
    check_frame(8'h07);
    @(negedge clk);
    bus_write(1'b0, 32'h03);
    @(negedge clk);
    check_frame(8'h03);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
